// File: rtl/fpga_sync_filter.sv
// Multi-bit synchroniser with per-bit debounce filter and registered rise/fall pulses.
// Each bit of source_data crosses into dest_clk, must persist FILTER_CYCLES cycles, then updates dest_data.
module fpga_sync_filter #(
  parameter int                     INPUT_WIDTH   = 8,
  parameter int                     SYNC_STAGES   = 2,
  parameter int                     FILTER_CYCLES = 4,
  parameter int                     CNT_WIDTH     = 8,
  parameter logic [INPUT_WIDTH-1:0] RESET_VALUE   = {INPUT_WIDTH{1'b0}}
) (
  input  logic                   dest_clk,
  input  logic                   dest_resetn,
  input  logic [INPUT_WIDTH-1:0] source_data,
  output logic [INPUT_WIDTH-1:0] dest_data,
  output logic [INPUT_WIDTH-1:0] dest_rise,
  output logic [INPUT_WIDTH-1:0] dest_fall
);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $fatal(1, "fpga_sync_filter: SYNC_STAGES must be at least 2");
  end
  if (FILTER_CYCLES < 1) begin : g_chk_filt_min
    $fatal(1, "fpga_sync_filter: FILTER_CYCLES must be at least 1");
  end
  if (longint'(FILTER_CYCLES) > (longint'(1) << CNT_WIDTH)) begin : g_chk_filt_max
    $fatal(1, "fpga_sync_filter: FILTER_CYCLES exceeds counter range");
  end

  // Terminal count: the FILTER_CYCLES-th consecutive mismatch commits the new level.
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(FILTER_CYCLES - 1);

  logic [INPUT_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [INPUT_WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [INPUT_WIDTH-1:0] sync_s;

  always_comb begin
    sync_d[0] = source_data;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_ff @(posedge dest_clk or negedge dest_resetn) begin
    if (!dest_resetn) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RESET_VALUE;
      end
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  genvar gi;
  for (gi = 0; gi < INPUT_WIDTH; gi++) begin : g_bit
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 data_q, data_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 update;

    always_comb begin
      cnt_d  = cnt_q;
      data_d = data_q;
      update = 1'b0;
      if (sync_s[gi] == data_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        update = 1'b1;
        data_d = sync_s[gi];
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      rise_d = update & sync_s[gi];
      fall_d = update & ~sync_s[gi];
    end

    always_ff @(posedge dest_clk or negedge dest_resetn) begin
      if (!dest_resetn) begin
        cnt_q  <= '0;
        data_q <= RESET_VALUE[gi];
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        data_q <= data_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign dest_data[gi] = data_q;
    assign dest_rise[gi] = rise_q;
    assign dest_fall[gi] = fall_q;
  end

endmodule

// File: tb/tb_fpga_sync_filter.sv
// Scoreboard bench: two filter configurations share one stimulus stream and are
// compared every cycle against a sliding-window reference model.
`timescale 1ns/1ps
module tb_fpga_sync_filter;

  localparam logic [7:0] RV_A = 8'hA5;
  localparam logic [7:0] RV_B = 8'h3C;
  localparam int S_A = 2, F_A = 4;
  localparam int S_B = 3, F_B = 1;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] r;
    logic [7:0] f;
  } exp_t;

  logic       dest_clk    = 1'b0;
  logic       dest_resetn = 1'b0;
  logic [7:0] source_data = 8'h00;
  logic [7:0] data_a, rise_a, fall_a;
  logic [7:0] data_b, rise_b, fall_b;

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [7:0] src_hist[$];
  logic [7:0] md_a = RV_A;
  logic [7:0] md_b = RV_B;
  bit         in_reset = 1'b1;
  int         n_vec = 0;
  int         n_err = 0;

  fpga_sync_filter #(
    .INPUT_WIDTH(8), .SYNC_STAGES(S_A), .FILTER_CYCLES(F_A), .CNT_WIDTH(8), .RESET_VALUE(RV_A)
  ) dut_a (
    .dest_clk(dest_clk), .dest_resetn(dest_resetn), .source_data(source_data),
    .dest_data(data_a), .dest_rise(rise_a), .dest_fall(fall_a)
  );

  fpga_sync_filter #(
    .INPUT_WIDTH(8), .SYNC_STAGES(S_B), .FILTER_CYCLES(F_B), .CNT_WIDTH(4), .RESET_VALUE(RV_B)
  ) dut_b (
    .dest_clk(dest_clk), .dest_resetn(dest_resetn), .source_data(source_data),
    .dest_data(data_b), .dest_rise(rise_b), .dest_fall(fall_b)
  );

  always #5 dest_clk = ~dest_clk;

  // Synchronised value seen by the filter at edge j (1-based since release).
  function automatic logic [7:0] s_at(input int j, input int s, input logic [7:0] rv);
    if (j - s >= 1) return src_hist[j-s-1];
    return rv;
  endfunction

  // A bit takes the new level once the last F filter samples all differ from it.
  function automatic void model_step(input int s, input int f, input logic [7:0] rv,
                                     input logic [7:0] d_in, output logic [7:0] d_out,
                                     output logic [7:0] r, output logic [7:0] fl);
    int         j;
    bit         all_diff;
    logic [7:0] sv;
    j     = src_hist.size();
    d_out = d_in;
    r     = 8'h00;
    fl    = 8'h00;
    for (int i = 0; i < 8; i++) begin
      all_diff = (j >= f);
      if (all_diff) begin
        for (int m = j - f + 1; m <= j; m++) begin
          sv = s_at(m, s, rv);
          if (sv[i] == d_in[i]) all_diff = 1'b0;
        end
      end
      if (all_diff) begin
        d_out[i] = ~d_in[i];
        r[i]     = ~d_in[i];
        fl[i]    = d_in[i];
      end
    end
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got d=%h r=%h f=%h, expected d=%h r=%h f=%h",
               name, $time, act.d, act.r, act.f, exp.d, exp.r, exp.f);
    end
  endtask

  // One stimulus cycle: drive at the falling edge, queue the response due after the next rising edge.
  task automatic cycle(input logic [7:0] v, input bit rst);
    logic [7:0] nd, r, f;
    @(negedge dest_clk);
    source_data = v;
    if (rst) begin
      dest_resetn = 1'b0;
      src_hist.delete();
      md_a = RV_A;
      md_b = RV_B;
      q_a.push_back(exp_t'({RV_A, 8'h00, 8'h00}));
      q_b.push_back(exp_t'({RV_B, 8'h00, 8'h00}));
      if (!in_reset) begin
        #1;
        check("async_reset_a", exp_t'({data_a, rise_a, fall_a}), exp_t'({RV_A, 8'h00, 8'h00}));
        check("async_reset_b", exp_t'({data_b, rise_b, fall_b}), exp_t'({RV_B, 8'h00, 8'h00}));
      end
      in_reset = 1'b1;
    end else begin
      dest_resetn = 1'b1;
      in_reset    = 1'b0;
      src_hist.push_back(v);
      model_step(S_A, F_A, RV_A, md_a, nd, r, f);
      md_a = nd;
      q_a.push_back(exp_t'({nd, r, f}));
      model_step(S_B, F_B, RV_B, md_b, nd, r, f);
      md_b = nd;
      q_b.push_back(exp_t'({nd, r, f}));
    end
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    repeat (n) cycle(v, 1'b0);
  endtask

  // Monitor: every rising edge is an output event for both instances.
  initial begin
    exp_t e;
    forever begin
      @(posedge dest_clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("dut_a", exp_t'({data_a, rise_a, fall_a}), e);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("dut_b", exp_t'({data_b, rise_b, fall_b}), e);
      end
    end
  end

  initial begin
    logic [7:0] v;
    int         len;

    // Reset with inputs low, then release: DUT A falls from A5 at edge 6.
    repeat (3) cycle(8'h00, 1'b1);
    hold(8'h00, 10);
    // Single step on bit 0.
    hold(8'h01, 10);
    // Bit 3 glitch of 3 cycles, then a 4-cycle pulse.
    hold(8'h09, 3);
    hold(8'h01, 10);
    hold(8'h09, 4);
    hold(8'h01, 10);
    // Bit 5 chatter every 2 cycles, then settle high.
    for (int k = 0; k < 20; k++) hold((k % 2) ? 8'h01 : 8'h21, 2);
    hold(8'h21, 12);
    // Bits 1 and 6 change together while bit 2 glitches.
    hold(8'h67, 2);
    hold(8'h63, 10);
    // Reset mid-count, then full latency again after release.
    hold(8'h00, 12);
    hold(8'h5A, 4);
    cycle(8'h5A, 1'b1);
    cycle(8'h5A, 1'b1);
    hold(8'h5A, 10);
    // Randomised runs of varying length with occasional resets.
    v = 8'h5A;
    for (int k = 0; k < 80; k++) begin
      v   = v ^ (8'($urandom) & 8'($urandom));
      len = $urandom_range(1, 7);
      if ($urandom_range(0, 19) == 0) cycle(v, 1'b1);
      hold(v, len);
    end
    hold(v, 10);

    repeat (2) @(posedge dest_clk);
    #2;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0", q_a.size(), q_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
